// File: rtl/ucount_capture.sv
// ucount_capture: event capture stage behind an 8-bit up/down counter.
// Detects compare matches, overflow rising edges and explicit capture
// requests. Queues one {source, dcount} entry per cycle into a small FIFO
// and keeps a saturating overflow counter.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   dcount     upstream counter value (unsigned)
//   overflow   upstream overflow flag
//   cmp_val    compare value
//   cmp_en     compare enable
//   capture    capture request, one event per high cycle
//   ovf_clr    clears ovf_cnt / ovf_sticky
//   out_ready  consumer ready
//   out_valid  FIFO head valid
//   out_data   dcount captured at the FIFO head
//   out_src    head source: 00 capture, 01 compare match, 10 overflow rise
//   match      one-cycle compare-match pulse
//   ovf_cnt    saturating overflow-rise count
//   ovf_sticky set on any overflow rise
//   dropped    sticky lost-event flag, cleared only by reset
module ucount_capture #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dcount,
  input  logic       overflow,
  input  logic [7:0] cmp_val,
  input  logic       cmp_en,
  input  logic       capture,
  input  logic       ovf_clr,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [1:0] out_src,
  output logic       match,
  output logic [7:0] ovf_cnt,
  output logic       ovf_sticky,
  output logic       dropped
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  localparam logic [1:0] SRC_CAPTURE = 2'b00;
  localparam logic [1:0] SRC_MATCH   = 2'b01;
  localparam logic [1:0] SRC_OVF     = 2'b10;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic eq, eq_q, ovf_q;
  logic m_ev, o_ev, c_ev;
  logic full, empty, pop, push_req, push, multi, lost;
  logic [1:0] push_src;

  always_comb begin
    eq       = cmp_en & (dcount == cmp_val);
    m_ev     = eq & ~eq_q;
    o_ev     = overflow & ~ovf_q;
    c_ev     = capture;
    full     = (count == FULL_CNT);
    empty    = (count == '0);
    pop      = ~empty & out_ready;
    push_req = o_ev | m_ev | c_ev;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push     = push_req & (~full | pop);
    multi    = (o_ev & m_ev) | (o_ev & c_ev) | (m_ev & c_ev);
    lost     = multi | (push_req & full & ~pop);
    push_src = SRC_CAPTURE;
    if (o_ev)      push_src = SRC_OVF;
    else if (m_ev) push_src = SRC_MATCH;
  end

  always_comb begin
    out_valid = ~empty;
    out_data  = '0;
    out_src   = '0;
    if (!empty) begin
      out_data = mem[rd_ptr][7:0];
      out_src  = mem[rd_ptr][9:8];
    end
  end

  // Edge-detect history loads during reset as well, so levels already high
  // at release are not seen as new events.
  always_ff @(posedge clk) begin
    eq_q  <= eq;
    ovf_q <= overflow;
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= {push_src, dcount};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      match      <= 1'b0;
      ovf_cnt    <= '0;
      ovf_sticky <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      match <= m_ev;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // A rise coinciding with a clear counts as the first event after it.
      if (ovf_clr) begin
        ovf_cnt    <= o_ev ? 8'd1 : 8'd0;
        ovf_sticky <= o_ev;
      end else if (o_ev) begin
        ovf_sticky <= 1'b1;
        if (ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
      end
      if (lost) dropped <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ucount_capture.sv
module tb_ucount_capture;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] dcount = '0;
  logic       overflow = 1'b0;
  logic [7:0] cmp_val = '0;
  logic       cmp_en = 1'b0;
  logic       capture = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_src;
  logic       match;
  logic [7:0] ovf_cnt;
  logic       ovf_sticky;
  logic       dropped;

  int checks = 0;
  int errors = 0;

  ucount_capture #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .dcount(dcount), .overflow(overflow),
    .cmp_val(cmp_val), .cmp_en(cmp_en), .capture(capture), .ovf_clr(ovf_clr),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .match(match), .ovf_cnt(ovf_cnt),
    .ovf_sticky(ovf_sticky), .dropped(dropped)
  );

  always #5 clk = ~clk;

  // Reference model: queue of {src, data} plus scalar flags.
  logic [9:0] mq[$];
  bit m_eq_prev, m_ovf_prev, m_match, m_sticky, m_drop;
  int m_cnt;

  task automatic model_step();
    bit eqv, mev, oev, cev;
    int n;
    eqv = cmp_en && (dcount == cmp_val);
    if (reset) begin
      mq.delete();
      m_match = 0; m_cnt = 0; m_sticky = 0; m_drop = 0;
    end else begin
      mev = eqv && !m_eq_prev;
      oev = overflow && !m_ovf_prev;
      cev = capture;
      n = int'(mev) + int'(oev) + int'(cev);
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (n > 1) m_drop = 1;
      if (n > 0) begin
        if (mq.size() < DEPTH)
          mq.push_back({oev ? 2'b10 : (mev ? 2'b01 : 2'b00), dcount});
        else
          m_drop = 1;
      end
      m_match = mev;
      if (ovf_clr) begin
        m_cnt = oev ? 1 : 0;
        m_sticky = oev;
      end else if (oev) begin
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_sticky = 1;
      end
    end
    m_eq_prev = eqv;
    m_ovf_prev = overflow;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [21:0] exp_vec();
    logic [9:0] h;
    h = (mq.size() > 0) ? mq[0] : 10'h0;
    return {mq.size() > 0, h[7:0], h[9:8], m_match, 8'(m_cnt), m_sticky, m_drop};
  endfunction

  // Head data/src are only meaningful while out_valid is high.
  function automatic logic [21:0] act_vec();
    return {out_valid, out_valid ? out_data : 8'h0, out_valid ? out_src : 2'b00,
            match, ovf_cnt, ovf_sticky, dropped};
  endfunction

  task automatic do_reset();
    reset = 1'b1; step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++;
    if ({out_valid, out_data, out_src, match, ovf_cnt, ovf_sticky, dropped} !== 22'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {out_valid, out_data, out_src, match, ovf_cnt, ovf_sticky, dropped});
    end
    reset = 1'b0;
    step();
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_release: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_compare();
    logic [7:0] seq [10] = '{8'hF6, 8'hF7, 8'hF8, 8'hF8, 8'hF8, 8'hF9, 8'hFA, 8'hFB, 8'hFC, 8'hFF};
    do_reset();
    cmp_val = 8'hF8; cmp_en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      dcount = seq[i];
      step();
      checks++;
      if (match !== (i == 2)) begin
        errors++; $display("FAIL cmp_match[%0d]: got %b want %b", i, match, (i == 2));
      end
    end
    checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, 2'b01, 8'hF8}) begin
      errors++; $display("FAIL cmp_entry: got v=%b src=%b data=%h want v=1 src=01 data=f8", out_valid, out_src, out_data);
    end
    cmp_en = 1'b0; out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL cmp_single_entry: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_ovf_sat();
    do_reset();
    out_ready = 1'b1; cmp_en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      overflow = 1'b1; step();
      overflow = 1'b0; step();
      if (i % 50 == 0) begin
        checks++;
        if (act_vec() !== exp_vec()) begin
          errors++; $display("FAIL ovf_progress[%0d]: got %h want %h", i, act_vec(), exp_vec());
        end
      end
    end
    checks++;
    if ({ovf_cnt, ovf_sticky} !== {8'd255, 1'b1}) begin
      errors++; $display("FAIL ovf_saturate: got cnt=%0d sticky=%b want cnt=255 sticky=1", ovf_cnt, ovf_sticky);
    end
    ovf_clr = 1'b1; step();
    ovf_clr = 1'b0;
    checks++;
    if ({ovf_cnt, ovf_sticky} !== 9'h0) begin
      errors++; $display("FAIL ovf_clear: got cnt=%0d sticky=%b want 0/0", ovf_cnt, ovf_sticky);
    end
    overflow = 1'b1; step();
    overflow = 1'b0; step();
    checks++;
    if ({ovf_cnt, ovf_sticky} !== {8'd1, 1'b1}) begin
      errors++; $display("FAIL ovf_after_clear: got cnt=%0d sticky=%b want 1/1", ovf_cnt, ovf_sticky);
    end
    overflow = 1'b1; step();
    overflow = 1'b0; step();
    ovf_clr = 1'b1; overflow = 1'b1; step();
    ovf_clr = 1'b0; overflow = 1'b0;
    checks++;
    if ({ovf_cnt, ovf_sticky} !== {8'd1, 1'b1}) begin
      errors++; $display("FAIL ovf_clr_with_rise: got cnt=%0d sticky=%b want 1/1", ovf_cnt, ovf_sticky);
    end
    step();
  endtask

  task automatic test_arbitration();
    do_reset();
    out_ready = 1'b0; cmp_en = 1'b0; overflow = 1'b0; capture = 1'b0;
    step();
    dcount = 8'hFF; cmp_val = 8'hFF; cmp_en = 1'b1; capture = 1'b1; overflow = 1'b1;
    step();
    checks++;
    if ({out_valid, out_src, out_data, dropped, match} !== {1'b1, 2'b10, 8'hFF, 1'b1, 1'b1}) begin
      errors++; $display("FAIL arb_entry: got v=%b src=%b data=%h drop=%b match=%b want 1 10 ff 1 1",
                         out_valid, out_src, out_data, dropped, match);
    end
    capture = 1'b0; overflow = 1'b0; cmp_en = 1'b0; out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL arb_single: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      dcount = 8'(i); capture = 1'b1;
      step();
      checks++;
      if (dropped !== (i == 5)) begin
        errors++; $display("FAIL full_dropped[%0d]: got %b want %b", i, dropped, (i == 5));
      end
    end
    capture = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if ({out_valid, out_data} !== {1'b1, 8'(k)}) begin
        errors++; $display("FAIL full_pop[%0d]: got v=%b data=%0d want v=1 data=%0d", k, out_valid, out_data, k);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL full_drained: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] expq[$];
    logic [7:0] got[$];
    logic [9:0] prev;
    bit stalled;
    do_reset();
    for (int cyc = 0; cyc < 24; cyc++) begin
      out_ready = (cyc % 2 == 0);
      if (cyc < 6) begin
        capture = 1'b1;
        dcount = 8'($urandom);
        expq.push_back(dcount);
      end else begin
        capture = 1'b0;
      end
      stalled = out_valid && !out_ready;
      prev = {out_src, out_data};
      if (out_valid && out_ready) got.push_back(out_data);
      step();
      if (stalled) begin
        checks++;
        if ({out_valid, out_src, out_data} !== {1'b1, prev}) begin
          errors++; $display("FAIL bp_stable[%0d]: got v=%b %h want v=1 %h", cyc, out_valid, {out_src, out_data}, prev);
        end
      end
    end
    checks++;
    if (got.size() != expq.size() || dropped !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_count: got %0d pops drop=%b v=%b want %0d pops drop=0 v=0",
                         got.size(), dropped, out_valid, expq.size());
    end
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      checks++;
      if (got[i] !== expq[i]) begin
        errors++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], expq[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dcount = 8'(10 + i); capture = 1'b1; step();
    end
    capture = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_queued: got out_valid=%b want 1", out_valid);
    end
    overflow = 1'b1; capture = 1'b1; out_ready = 1'b1; reset = 1'b1;
    step();
    checks++;
    if ({out_valid, out_data, out_src, match, ovf_cnt, ovf_sticky, dropped} !== 22'h0) begin
      errors++; $display("FAIL rstmid_outputs: got %h want 0", {out_valid, out_data, out_src, match, ovf_cnt, ovf_sticky, dropped});
    end
    reset = 1'b0; capture = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({out_valid, ovf_cnt, ovf_sticky, dropped} !== 11'h0) begin
        errors++; $display("FAIL rstmid_no_event[%0d]: got v=%b cnt=%0d sticky=%b drop=%b want all 0",
                           i, out_valid, ovf_cnt, ovf_sticky, dropped);
      end
    end
    overflow = 1'b0; out_ready = 1'b0;
    step();
  endtask

  task automatic test_random();
    do_reset();
    dcount = 8'($urandom);
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) cmp_val = dcount + 8'($urandom_range(0, 3));
      dcount    = ($urandom_range(0, 1) == 1) ? dcount + 8'd1 : dcount - 8'd1;
      overflow  = ($urandom_range(0, 3) == 0);
      cmp_en    = ($urandom_range(0, 7) != 0);
      capture   = ($urandom_range(0, 3) == 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 99) == 0);
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL random[%0d]: got %h want %h", i, act_vec(), exp_vec());
      end
    end
    reset = 1'b0; capture = 1'b0; overflow = 1'b0; ovf_clr = 1'b0; cmp_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_compare();
    test_ovf_sat();
    test_arbitration();
    test_fifo_full();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
